cnt_seq_checker: RTL and testbench
==================================

Name: cnt_seq_checker

Overview:
- Sequence checker for the free-running 32-bit counter stream. It is the consumer end of the counter generator.
- Samples an incoming count value on each valid cycle and locks onto the +1 sequence after a run of consecutive matches.
- Once locked, it flags and counts every break in the sequence and drops lock after repeated consecutive breaks.
- Sits beside the counter in the top level as a self-check and trust monitor.

Parameters:
- WIDTH, 32: data width of the observed count; arithmetic is modulo 2^WIDTH.
- LOCK_CNT, 4: consecutive matching samples needed to assert lock. Legal range 2..255.
- LOSS_CNT, 3: consecutive mismatches in LOCKED that drop lock. Legal range 1..255.
- ERRW, 16: width of the saturating error counter.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is a sample this cycle.
- in_data  in  WIDTH  observed count value.
- clr_err  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatch detected in LOCKED.
- err_count  out  ERRW  saturating count of mismatches detected in LOCKED.
- expected  out  WIDTH  next value the checker expects.

Behaviour:
- Reset values: locked=0, err_pulse=0, err_count=0, expected=0. Internal: state=UNLOCKED, run=0, miss=0.
- RST has priority over every other input and may arrive mid-sequence.
- All outputs are registered. A sample accepted at edge k updates the outputs at that edge, so they are visible in the cycle after the sample. There is no other latency.
- "match" means in_data == expected. expected always advances modulo 2^WIDTH, so 2^WIDTH-1 followed by 0 is a match.
- Cycles with in_valid=0 change no state and no counters, and err_pulse=0.
- State UNLOCKED, on a valid sample: expected <= in_data+1, run <= 1, go to ACQUIRE.
- State ACQUIRE, on a valid sample:
  - match: run <= run+1, expected <= in_data+1. If run+1 == LOCK_CNT, go to LOCKED with miss <= 0.
  - mismatch: reseed with expected <= in_data+1, run <= 1, stay in ACQUIRE.
  - err_pulse and err_count never change in ACQUIRE.
- State LOCKED, on a valid sample:
  - match: expected <= expected+1, miss <= 0.
  - mismatch: err_pulse <= 1, err_count increments (saturates at all-ones), miss <= miss+1.
  - If miss+1 < LOSS_CNT: expected <= expected+1, i.e. free-run and do not resync to the bad data.
  - If miss+1 == LOSS_CNT: go to ACQUIRE with expected <= in_data+1, run <= 1, locked drops at the same edge.
- err_pulse is high for exactly one cycle per counted mismatch, never longer.
- clr_err sets err_count to 0. If clr_err coincides with a counted mismatch, err_count becomes 1 (the clear applies first, then the increment).
- When err_count is saturated, a further mismatch still pulses err_pulse but leaves err_count unchanged.
- Generator reset (stream drops back to 0) while LOCKED is an ordinary mismatch. It resyncs only through the LOSS_CNT path.
- The checker does not backpressure; every valid sample is consumed.

Test Plan:
- Lock: RST, then valid samples 5,6,7,8 -> locked=1 after the 4th sample, expected=9, err_count=0, no err_pulse.
- Wrap: lock on FFFFFFFC..FFFFFFFF, then feed 0,1 -> locked stays 1, no errors, expected=2.
- Single glitch: locked at expected=20, feed 20,21,99,23,24 -> one err_pulse on the 99 sample, err_count=1, locked stays 1, expected=25.
- Loss and reacquire: locked at expected=10, feed 0,1,2 -> 3 err_pulses, err_count=3, locked=0 after the third sample, expected=3. Then feed 3,4,5 -> locked=1 after the 5, since the run counts 2,3,4,5 = 4 samples.
- Acquire reseed: from reset, feed 1,2,7,8,9,10 -> no err_pulse, err_count=0, locked=1 after the 10.
- Clear, saturation and reset: clr_err together with a mismatch -> err_count=1. With ERRW=2, 5 spaced glitches -> err_count=3 and 5 err_pulses. RST asserted mid-lock -> next cycle locked=0, err_count=0, expected=0.

Source files
------------

// File: rtl/cnt_seq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cnt_seq_checker                                               |
// | Purpose  : Consumer-side checker for a free-running counter stream.      |
// |            It locks onto the +1 sequence after LOCK_CNT consecutive      |
// |            matching samples. While locked it flags and counts each break |
// |            in the sequence, and it drops lock after LOSS_CNT consecutive |
// |            breaks.                                                       |
// | Ports    : CLK, RST     clock, synchronous active-high reset             |
// |            in_valid     in_data carries a sample this cycle              |
// |            in_data      observed count value (WIDTH bits)                |
// |            clr_err      synchronous clear of err_count                   |
// |            locked       high while the sequence is trusted               |
// |            err_pulse    one-cycle pulse per mismatch seen while locked   |
// |            err_count    saturating mismatch count (ERRW bits)            |
// |            expected     next value the checker expects                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cnt_seq_checker #(
  parameter int WIDTH    = 32,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERRW     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // Both thresholds are limited to 255, so 8-bit run/miss counters are
  // sufficient. Comparisons are done at 9 bits so the increment cannot wrap.
  localparam logic [8:0] c_lock_cnt = 9'(LOCK_CNT);
  localparam logic [8:0] c_loss_cnt = 9'(LOSS_CNT);

  state_t           r_state, w_state_nx;
  logic [7:0]       r_run, w_run_nx;
  logic [7:0]       r_miss, w_miss_nx;
  logic [WIDTH-1:0] r_expected, w_expected_nx;
  logic [ERRW-1:0]  r_err_count, w_err_count_nx;
  logic             r_err_pulse, w_err_pulse_nx;

  logic             w_match;
  logic [8:0]       w_run_inc;
  logic [8:0]       w_miss_inc;
  logic [WIDTH-1:0] w_data_inc;
  logic [ERRW-1:0]  w_err_base;

  assign w_match    = (in_data == r_expected);
  assign w_run_inc  = {1'b0, r_run} + 9'd1;
  assign w_miss_inc = {1'b0, r_miss} + 9'd1;
  assign w_data_inc = in_data + {{(WIDTH-1){1'b0}}, 1'b1};
  // The clear is applied before any increment in the same cycle.
  assign w_err_base = clr_err ? '0 : r_err_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_UNLOCKED;
      r_run       <= '0;
      r_miss      <= '0;
      r_expected  <= '0;
      r_err_count <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_run       <= w_run_nx;
      r_miss      <= w_miss_nx;
      r_expected  <= w_expected_nx;
      r_err_count <= w_err_count_nx;
      r_err_pulse <= w_err_pulse_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_run_nx       = r_run;
    w_miss_nx      = r_miss;
    w_expected_nx  = r_expected;
    w_err_count_nx = w_err_base;
    w_err_pulse_nx = 1'b0;

    if (in_valid) begin
      case (r_state)
        ST_UNLOCKED: begin
          w_expected_nx = w_data_inc;
          w_run_nx      = 8'd1;
          w_state_nx    = ST_ACQUIRE;
        end

        ST_ACQUIRE: begin
          // Both outcomes follow the incoming data. A mismatch restarts the run.
          w_expected_nx = w_data_inc;
          if (w_match) begin
            w_run_nx = w_run_inc[7:0];
            if (w_run_inc == c_lock_cnt) begin
              w_state_nx = ST_LOCKED;
              w_miss_nx  = 8'd0;
            end
          end else begin
            w_run_nx = 8'd1;
          end
        end

        ST_LOCKED: begin
          if (w_match) begin
            w_expected_nx = r_expected + {{(WIDTH-1){1'b0}}, 1'b1};
            w_miss_nx     = 8'd0;
          end else begin
            w_err_pulse_nx = 1'b1;
            if (w_err_base != '1) begin
              w_err_count_nx = w_err_base + {{(ERRW-1){1'b0}}, 1'b1};
            end
            if (w_miss_inc < c_loss_cnt) begin
              // Free-run past an isolated glitch and do not resync to the bad data.
              w_miss_nx     = w_miss_inc[7:0];
              w_expected_nx = r_expected + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
              w_state_nx    = ST_ACQUIRE;
              w_miss_nx     = 8'd0;
              w_expected_nx = w_data_inc;
              w_run_nx      = 8'd1;
            end
          end
        end

        default: begin
          w_state_nx = ST_UNLOCKED;
        end
      endcase
    end
  end

  assign locked    = (r_state == ST_LOCKED);
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign expected  = r_expected;

endmodule
`default_nettype wire

// File: tb/tb_cnt_seq_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cnt_seq_checker                                            |
// | Purpose  : Self-checking bench for cnt_seq_checker. It drives two        |
// |            instances from the same stimulus: one with the default        |
// |            parameters and one with ERRW=2 to exercise saturation.        |
// |            A sample-level reference model is compared against both       |
// |            instances every cycle. Directed scenarios also pin literal    |
// |            values.                                                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_cnt_seq_checker;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        clr_err = 1'b0;

  logic        locked_a, pulse_a;
  logic [15:0] cnt_a;
  logic [31:0] exp_a;
  logic        locked_b, pulse_b;
  logic [1:0]  cnt_b;
  logic [31:0] exp_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int pulses_b = 0;

  always #5 CLK = ~CLK;

  cnt_seq_checker dut_a (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
    .clr_err(clr_err), .locked(locked_a), .err_pulse(pulse_a),
    .err_count(cnt_a), .expected(exp_a)
  );

  cnt_seq_checker #(.ERRW(2)) dut_b (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
    .clr_err(clr_err), .locked(locked_b), .err_pulse(pulse_b),
    .err_count(cnt_b), .expected(exp_b)
  );

  // Reference model, expressed per accepted sample.
  // m_seen: at least one sample has arrived since reset or since lock was lost.
  bit          m_locked, m_seen, m_pulse;
  int          m_run, m_miss, m_err16, m_err2;
  logic [31:0] m_exp;

  always @(posedge CLK) begin
    if (RST) begin
      m_locked = 0; m_seen = 0; m_pulse = 0;
      m_run = 0; m_miss = 0; m_err16 = 0; m_err2 = 0; m_exp = 0;
    end else begin
      m_pulse = 0;
      if (clr_err) begin m_err16 = 0; m_err2 = 0; end
      if (in_valid) begin
        if (!m_locked) begin
          if (m_seen && in_data == m_exp) m_run = m_run + 1;
          else m_run = 1;
          m_seen = 1;
          m_exp  = in_data + 32'd1;
          if (m_run == 4) begin m_locked = 1; m_miss = 0; end
        end else begin
          if (in_data == m_exp) m_miss = 0;
          else begin
            m_pulse = 1;
            m_miss  = m_miss + 1;
            if (m_err16 < 65535) m_err16 = m_err16 + 1;
            if (m_err2 < 3) m_err2 = m_err2 + 1;
          end
          if (m_miss == 3) begin
            m_locked = 0; m_seen = 1; m_run = 1; m_miss = 0;
            m_exp = in_data + 32'd1;
          end else begin
            m_exp = m_exp + 32'd1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("locked_a",  64'(locked_a), 64'(m_locked));
      check("pulse_a",   64'(pulse_a),  64'(m_pulse));
      check("count_a",   64'(cnt_a),    64'(m_err16));
      check("expected_a",64'(exp_a),    64'(m_exp));
      check("locked_b",  64'(locked_b), 64'(m_locked));
      check("pulse_b",   64'(pulse_b),  64'(m_pulse));
      check("count_b",   64'(cnt_b),    64'(m_err2));
      check("expected_b",64'(exp_b),    64'(m_exp));
      if (pulse_b) pulses_b++;
    end
  end

  task automatic step(input bit v, input logic [31:0] d, input bit c, input bit r);
    in_valid = v; in_data = d; clr_err = c; RST = r;
    @(posedge CLK); #1;
    in_valid = 0; clr_err = 0; RST = 0;
  endtask

  task automatic feed(input logic [31:0] d);
    step(1, d, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1);
  endtask

  // Literal checks against both the DUT and the model.
  task automatic pin(input string name, input bit lk, input bit pl, input int cnt, input logic [31:0] ex);
    check({name, "_locked"},   64'(locked_a), 64'(lk));
    check({name, "_pulse"},    64'(pulse_a),  64'(pl));
    check({name, "_count"},    64'(cnt_a),    64'(cnt));
    check({name, "_expected"}, 64'(exp_a),    64'(ex));
    check({name, "_model_lk"}, 64'(m_locked), 64'(lk));
    check({name, "_model_ex"}, 64'(m_exp),    64'(ex));
    check({name, "_model_ct"}, 64'(m_err16),  64'(cnt));
  endtask

  initial begin
    logic [31:0] g;
    int r;

    // Reset state
    do_reset();
    chk_en = 1;
    pin("reset", 0, 0, 0, 32'd0);

    // Lock onto 5,6,7,8
    feed(5); feed(6); feed(7);
    pin("prelock", 0, 0, 0, 32'd8);
    feed(8);
    pin("lock", 1, 0, 0, 32'd9);

    // Wrap-around while locked
    do_reset();
    feed(32'hFFFFFFFC); feed(32'hFFFFFFFD); feed(32'hFFFFFFFE); feed(32'hFFFFFFFF);
    pin("wrap_lock", 1, 0, 0, 32'd0);
    feed(0); feed(1);
    pin("wrap", 1, 0, 0, 32'd2);

    // Single glitch
    do_reset();
    feed(16); feed(17); feed(18); feed(19);
    feed(20); feed(21); feed(99);
    pin("glitch", 1, 1, 1, 32'd23);
    feed(23);
    pin("glitch_after", 1, 0, 1, 32'd24);
    feed(24);
    pin("glitch_end", 1, 0, 1, 32'd25);

    // Loss and reacquire
    do_reset();
    feed(6); feed(7); feed(8); feed(9);
    feed(0); feed(1);
    pin("loss_2", 1, 1, 2, 32'd12);
    feed(2);
    pin("loss", 0, 1, 3, 32'd3);
    feed(3); feed(4);
    pin("reacq_4", 0, 0, 3, 32'd5);
    feed(5);
    pin("reacq", 1, 0, 3, 32'd6);

    // Acquire reseed
    do_reset();
    feed(1); feed(2); feed(7); feed(8); feed(9);
    pin("reseed_9", 0, 0, 0, 32'd10);
    feed(10);
    pin("reseed", 1, 0, 0, 32'd11);

    // Invalid cycles change nothing
    step(0, 32'd555, 0, 0); step(0, 32'd0, 0, 0);
    pin("idle", 1, 0, 0, 32'd11);

    // Clear coinciding with a mismatch
    feed(50); feed(12);
    pin("pre_clr", 1, 0, 1, 32'd13);
    step(1, 32'd77, 1, 0);
    pin("clr_mismatch", 1, 1, 1, 32'd14);
    step(0, 0, 1, 0);
    pin("clr_only", 1, 0, 0, 32'd14);

    // Saturation on the ERRW=2 instance: five spaced glitches
    do_reset();
    feed(0); feed(1); feed(2); feed(3);
    pulses_b = 0;
    for (int i = 0; i < 5; i++) begin
      feed(32'hDEAD0000);
      feed(32'd4 + 32'(2*i) + 32'd1);
    end
    check("sat_count_b", 64'(cnt_b), 64'd3);
    check("sat_pulses_b", 64'(pulses_b), 64'd5);
    pin("sat_a", 1, 0, 5, 32'd14);

    // Reset asserted while locked
    do_reset();
    pin("rst_mid", 0, 0, 0, 32'd0);

    // Randomized stream: mostly well-formed counts with glitches, gaps,
    // jumps, clears and occasional resets.
    g = $urandom;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 5) begin
        do_reset();
      end else begin
        if (r < 25) g = $urandom;
        else if (r < 35) g = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
        else if (r < 45) g = 32'd0;
        if (r >= 850) begin
          step(0, $urandom, (r >= 990), 0);
        end else if (r >= 780 && r < 850) begin
          step(1, $urandom, (r < 790), 0);
          g = g + 32'd1;
        end else begin
          step(1, g, 0, 0);
          g = g + 32'd1;
        end
      end
    end

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
